// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// {Cout, Sum} = A + B + Cin after WIDTH shift cycles, flagged by a one-cycle done strobe.

module full_adder_ins (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

module serial_adder_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             fa_sum;
  logic             fa_cout;

  full_adder_ins u_fa (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            psum_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          // Partial sum fills from the top so bit 0 ends up holding the first computed bit.
          psum_q  <= {fa_sum, psum_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            Sum     <= {fa_sum, psum_q[WIDTH-1:1]};
            Cout    <= fa_cout;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Directed checks of the bit-serial adder at WIDTH=8, plus back-to-back random runs
// at WIDTH=8 and WIDTH=4 against A+B+Cin.

module tb_serial_adder_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, start4, cin4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       busy8, done8, cout8;
  logic       busy4, done4, cout4;
  logic [8:0] last8;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  serial_adder_8bit #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Cout  (cout8)
  );

  serial_adder_8bit #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .Cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .Sum   (sum4),
    .Cout  (cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; optionally pulse start with other operands before edge glitch.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [8:0] prev, input logic [8:0] exp, input int glitch);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin;
    for (int k = 1; k <= 8; k++) begin
      chk("busy_run", busy8, 1'b1);
      chk("done_early", done8, 1'b0);
      chk("result_hold", {cout8, sum8}, prev);
      if (k == glitch) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      end else begin
        start8 = 1'b0;
      end
      step();
    end
    start8 = 1'b0;
    chk("busy_end", busy8, 1'b0);
    chk("done_pulse", done8, 1'b1);
    chk("result", {cout8, sum8}, exp);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("done_after", done8, 1'b0);
      chk("busy_after", busy8, 1'b0);
      chk("result_stable", {cout8, sum8}, exp);
    end
    last8 = exp;
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done4;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy4;
  endfunction

  function automatic logic [8:0] get_res(input int w);
    return (w == 8) ? {cout8, sum8} : {4'b0, cout4, sum4};
  endfunction

  task automatic set_ops(input int w, input logic [7:0] a, input logic [7:0] b,
                         input logic c);
    if (w == 8) begin
      a8 = a; b8 = b; cin8 = c;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = c;
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 8) start8 = v;
    else start4 = v;
  endtask

  // start held high: each op is accepted exactly w+2 edges after the previous one.
  task automatic back_to_back(input int w, input int nops);
    logic [7:0] mask, na, nb;
    logic       nc;
    logic [8:0] exp;
    mask = (w == 8) ? 8'hFF : 8'h0F;
    na = 8'($urandom) & mask; nb = 8'($urandom) & mask; nc = 1'($urandom);
    set_ops(w, na, nb, nc);
    set_start(w, 1'b1);
    step();
    exp = {1'b0, na} + {1'b0, nb} + {8'b0, nc};
    for (int i = 0; i < nops; i++) begin
      na = 8'($urandom) & mask; nb = 8'($urandom) & mask; nc = 1'($urandom);
      set_ops(w, na, nb, nc);
      for (int k = 1; k < w; k++) begin
        step();
        chk("bb_busy", get_busy(w), 1'b1);
        chk("bb_done_early", get_done(w), 1'b0);
      end
      step();
      chk("bb_done", get_done(w), 1'b1);
      chk("bb_result", get_res(w), exp);
      step();
      chk("bb_done_clear", get_done(w), 1'b0);
      if (i == nops - 1) set_start(w, 1'b0);
      step();
      chk("bb_restart_busy", get_busy(w), (i == nops - 1) ? 1'b0 : 1'b1);
      exp = {1'b0, na} + {1'b0, nb} + {8'b0, nc};
    end
    for (int k = 0; k < w + 4; k++) begin
      step();
      chk("bb_idle_done", get_done(w), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    last8 = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_outs", {busy8, done8, cout8, sum8}, 32'h0);
      step();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_outs", {busy8, done8, cout8, sum8}, 32'h0);
    end

    run8(8'h0F, 8'h01, 1'b0, last8, 9'h010, 0);
    run8(8'hFF, 8'h01, 1'b0, last8, 9'h100, 0);
    run8(8'hFF, 8'hFF, 1'b1, last8, 9'h1FF, 0);
    run8(8'h12, 8'h34, 1'b0, last8, 9'h046, 3);

    // Reset in the middle of an operation.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy8, done8, cout8, sum8}, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    chk("abort_held", {busy8, done8, cout8, sum8}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("abort_no_done", {busy8, done8}, 2'b00);
    end
    last8 = '0;
    run8(8'h80, 8'h80, 1'b1, last8, 9'h101, 0);

    back_to_back(8, 200);
    back_to_back(4, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
